// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size/state encodings and request record for the byte-serial memory access unit
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Zero marks the illegal encoding so callers can fold it into the legality check.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_bytes = 3'd1;
            SZ_HALF: size_to_bytes = 3'd2;
            SZ_WORD: size_to_bytes = 3'd4;
            default: size_to_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core request/response and byte-wide memory bus bundle
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [7:0]  mem_read_data;

    // master: core plus data memory; slave: the access unit
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - sign/zero extension of assembled load lanes
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);
    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata = {{24{!is_unsigned && lanes[7]}}, lanes[7:0]};
            SZ_HALF: rdata = {{16{!is_unsigned && lanes[15]}}, lanes[15:0]};
            SZ_WORD: rdata = lanes;
            default: rdata = '0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequences byte/half/word loads and stores as one-byte memory cycles
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    logic [1:0]  state;
    logic [1:0]  byte_cnt;
    mem_req_t    req_q;
    logic [31:0] lanes;
    logic [31:0] lanes_next;
    logic [31:0] ext_rdata;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [2:0]  req_n;
    logic [2:0]  cur_n;
    logic [32:0] req_last;
    logic        req_legal;
    logic        last_byte;

    // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        req_n     = size_to_bytes(bus.req_size);
        req_last  = {1'b0, bus.req_addr} + 33'(req_n) - 33'd1;
        req_legal = (req_n != 3'd0)
                 && ((bus.req_addr & (32'(req_n) - 32'd1)) == 32'd0)
                 && (req_last < 33'(MEM_BYTES));
        cur_n     = size_to_bytes(req_q.size);
        last_byte = ({1'b0, byte_cnt} == (cur_n - 3'd1));
        lanes_next = lanes;
        if (state == ACCESS && !req_q.write)
            lanes_next[8*byte_cnt +: 8] = bus.mem_read_data;
    end

    // Fed with lanes_next so the final byte is included on the edge into RESP.
    load_extend u_load_extend (
        .lanes       (lanes_next),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .rdata       (ext_rdata)
    );

    assign bus.req_ready        = (state == IDLE);
    assign bus.resp_valid       = (state == RESP);
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.resp_error       = resp_error_q;
    assign bus.mem_read_enable  = (state == ACCESS) && !req_q.write;
    assign bus.mem_write_enable = (state == ACCESS) && req_q.write;
    assign bus.mem_address      = (state == ACCESS) ? req_q.addr + {30'd0, byte_cnt} : 32'd0;
    assign bus.mem_write_data   = (state == ACCESS && req_q.write) ? req_q.wdata[8*byte_cnt +: 8] : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            req_q        <= '0;
            lanes        <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= '{write: bus.req_write, size: bus.req_size,
                                   is_unsigned: bus.req_unsigned,
                                   addr: bus.req_addr, wdata: bus.req_wdata};
                        byte_cnt <= '0;
                        lanes    <= '0;
                        if (req_legal) begin
                            state <= ACCESS;
                        end else begin
                            state        <= RESP;
                            resp_rdata_q <= '0;
                            resp_error_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    lanes <= lanes_next;
                    if (last_byte) begin
                        state        <= RESP;
                        resp_rdata_q <= req_q.write ? 32'd0 : ext_rdata;
                        resp_error_q <= 1'b0;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(512)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] tb_mem  [0:511];
    logic [7:0] ref_mem [0:511];

    // Garbage byte while disabled exposes any sampling outside a read cycle.
    assign bus.mem_read_data = bus.mem_read_enable ? tb_mem[bus.mem_address[8:0]] : 8'hA5;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= 8'h00;
        end else if (bus.mem_write_enable) begin
            tb_mem[bus.mem_address[8:0]] <= bus.mem_write_data;
        end
    end

    int checks = 0;
    int passed = 0;
    int both_en = 0;

    always @(negedge clk)
        if (bus.mem_write_enable && bus.mem_read_enable) both_en++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int ref_n(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        if (sz == 2'b10) return 4;
        return 0;
    endfunction

    function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
        longint n = longint'(ref_n(sz));
        longint la = longint'({32'd0, a});
        if (n == 0) return 1'b0;
        if (la % n != 0) return 1'b0;
        return (la + n - 1) < 512;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        longint v = 0;
        int n = ref_n(sz);
        for (int k = 0; k < n; k++)
            v = v + (longint'(ref_mem[(a + 32'(k)) & 32'h1FF]) << (8 * k));
        if (!u && ((v >> (8 * n - 1)) & 1) == 1)
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = ref_n(sz);
        for (int k = 0; k < n; k++)
            ref_mem[(a + 32'(k)) & 32'h1FF] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int cyc;
        int en_cyc;
        @(negedge clk);
        chk("ready_before", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(negedge clk);
        cyc = 1;
        en_cyc = 0;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        while (!bus.resp_valid && cyc < 12) begin
            if (bus.mem_read_enable || bus.mem_write_enable) begin
                en_cyc++;
                chk("mem_address", bus.mem_address, a + 32'(cyc - 1));
                chk("mem_direction", {31'd0, bus.mem_write_enable}, {31'd0, w});
                if (w) chk("mem_write_data", {24'd0, bus.mem_write_data}, (wd >> (8 * (cyc - 1))) & 32'hFF);
            end
            @(negedge clk);
            cyc++;
        end
        chk("resp_valid_seen", {31'd0, bus.resp_valid}, 32'd1);
        chk("latency", cyc, exp_lat);
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("resp_error", {31'd0, bus.resp_error}, {31'd0, exp_err});
        chk("enable_cycles", en_cyc, exp_err ? 0 : exp_lat - 1);
        @(negedge clk);
        chk("resp_pulse_end", {31'd0, bus.resp_valid}, 32'd0);
        chk("resp_rdata_hold", bus.resp_rdata, exp_rd);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        w, u, legal;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_rd, exp1, exp2;

        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0, 5};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 5};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h21,       32'h00000080, 32'h00000000, 1'b0, 2};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        32'hFFFFFF80, 1'b0, 2};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h21,       32'h0,        32'h00000080, 1'b0, 2};
        vt[5]  = '{1'b1, 2'b01, 1'b0, 32'h40,       32'h00008001, 32'h00000000, 1'b0, 3};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h40,       32'h0,        32'hFFFF8001, 1'b0, 3};
        vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h40,       32'h0,        32'h00008001, 1'b0, 3};
        vt[8]  = '{1'b0, 2'b10, 1'b0, 32'h12,       32'h0,        32'h00000000, 1'b1, 1};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h1FE,      32'h0,        32'h00000000, 1'b1, 1};
        vt[10] = '{1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1, 1};
        vt[11] = '{1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1, 1};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'h1FC,      32'h0,        32'h00000000, 1'b0, 5};
        vt[13] = '{1'b0, 2'b00, 1'b1, 32'h1FF,      32'h0,        32'h00000000, 1'b0, 2};
        vt[14] = '{1'b1, 2'b01, 1'b0, 32'h11,       32'h1234,     32'h00000000, 1'b1, 1};

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        chk("rst_enables",    {30'd0, bus.mem_write_enable, bus.mem_read_enable}, 32'd0);
        chk("rst_mem_addr",   bus.mem_address, 32'd0);
        chk("rst_mem_wdata",  {24'd0, bus.mem_write_data}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_req(vt[i].w, vt[i].sz, vt[i].u, vt[i].a, vt[i].wd, vt[i].rd, vt[i].err, vt[i].lat);
            if (vt[i].w && !vt[i].err) ref_store(vt[i].a, vt[i].sz, vt[i].wd);
            if (i == 0)
                chk("mem_bytes_10_13", {tb_mem[19], tb_mem[18], tb_mem[17], tb_mem[16]}, 32'hDEADBEEF);
        end

        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 130)) * 32'd4;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
            else if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
            else if (sz == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
            wd = $urandom;
            legal  = ref_legal(sz, a);
            exp_rd = (legal && !w) ? ref_load(a, sz, u) : 32'd0;
            do_req(w, sz, u, a, wd, exp_rd, !legal, legal ? ref_n(sz) + 1 : 1);
            if (legal && w) ref_store(a, sz, wd);
        end

        // Back-to-back: req_valid held high, second request must wait for IDLE in cycle 6.
        exp1 = ref_load(32'h10, 2'b10, 1'b0);
        exp2 = ref_load(32'h40, 2'b10, 1'b0);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_addr = 32'h40;
            if (c == 7) bus.req_valid = 1'b0;
            chk("b2b_ready", {31'd0, bus.req_ready}, {31'd0, c == 6});
            chk("b2b_rd_en", {31'd0, bus.mem_read_enable}, {31'd0, (c >= 1 && c <= 4) || (c >= 7 && c <= 10)});
            chk("b2b_resp_valid", {31'd0, bus.resp_valid}, {31'd0, c == 5 || c == 11});
            if (c <= 4) chk("b2b_addr1", bus.mem_address, 32'h10 + 32'(c - 1));
            if (c >= 7 && c <= 10) chk("b2b_addr2", bus.mem_address, 32'h40 + 32'(c - 7));
            if (c == 5) chk("b2b_rdata1", bus.resp_rdata, exp1);
            if (c == 11) chk("b2b_rdata2", bus.resp_rdata, exp2);
        end

        // Reset during cycle 2 of a word store at 0x0.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h11223344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid_store_started", {31'd0, bus.mem_write_enable}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        chk("rst_mid_ready",      {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_enables",    {30'd0, bus.mem_write_enable, bus.mem_read_enable}, 32'd0);
        chk("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mid_rdata",      bus.resp_rdata, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5);

        chk("never_both_enables", both_en, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
